divider_21_bits: RTL and testbench

//  Sequential signed integer divider for 21-bit two's-complement operands,

---
 rtl/divider_21_bits.sv | 135 +++++++++++++
 tb/tb_divider_21_bits.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider_21_bits.sv
// rtl/divider_21_bits.sv - sequential signed 21-bit restoring divider, one quotient bit per cycle
module divider_21_bits #(
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             open,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             finish,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic             open_q, open_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             sign_q, sign_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             dbz_q, dbz_d;
  logic [CW-1:0]    count_q, count_d;
  logic             finish_q, finish_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;

  logic             start;
  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] diff;
  logic             q_bit;
  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] result;

  always_comb begin
    state_d    = state_q;
    open_d     = open;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    sign_d     = sign_q;
    dvd_neg_d  = dvd_neg_q;
    dbz_d      = dbz_q;
    count_d    = count_q;
    finish_d   = finish_q;
    quotient_d = quotient_q;

    start     = open & ~open_q;
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    diff      = rem_shift - {2'b00, dvs_q};
    q_bit     = ~diff[WIDTH+1];
    mag       = {quo_q[WIDTH-2:0], q_bit};

    // Magnitude MSB set with a positive sign only happens for -2^(W-1) / -1.
    if (dbz_q)
      result = dvd_neg_q ? MIN_NEG : MAX_POS;
    else if (!sign_q && mag[WIDTH-1])
      result = MAX_POS;
    else if (sign_q)
      result = {WIDTH{1'b0}} - mag;
    else
      result = mag;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          dvd_d     = dividend[WIDTH-1] ? ({WIDTH{1'b0}} - dividend) : dividend;
          dvs_d     = divisor[WIDTH-1] ? ({WIDTH{1'b0}} - divisor) : divisor;
          sign_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          dvd_neg_d = dividend[WIDTH-1];
          dbz_d     = (divisor == {WIDTH{1'b0}});
          rem_d     = '0;
          quo_d     = '0;
          count_d   = '0;
          finish_d  = 1'b0;
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        rem_d   = q_bit ? diff[WIDTH:0] : rem_shift[WIDTH:0];
        dvd_d   = {dvd_q[WIDTH-2:0], 1'b0};
        quo_d   = mag;
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          quotient_d = result;
          finish_d   = 1'b1;
          state_d    = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      open_q     <= 1'b0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      sign_q     <= 1'b0;
      dvd_neg_q  <= 1'b0;
      dbz_q      <= 1'b0;
      count_q    <= '0;
      finish_q   <= 1'b0;
      quotient_q <= '0;
    end else begin
      state_q    <= state_d;
      open_q     <= open_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      sign_q     <= sign_d;
      dvd_neg_q  <= dvd_neg_d;
      dbz_q      <= dbz_d;
      count_q    <= count_d;
      finish_q   <= finish_d;
      quotient_q <= quotient_d;
    end
  end

  assign finish   = finish_q;
  assign quotient = quotient_q;

endmodule

// File: tb/tb_divider_21_bits.sv
// tb/tb_divider_21_bits.sv - directed self-checking bench for divider_21_bits
module tb_divider_21_bits;

  logic        clk = 1'b0;
  logic        rst;
  logic        open;
  logic [20:0] dividend;
  logic [20:0] divisor;
  logic        finish;
  logic [20:0] quotient;

  int checks = 0;
  int errors = 0;

  divider_21_bits dut (
    .clk      (clk),
    .rst      (rst),
    .open     (open),
    .dividend (dividend),
    .divisor  (divisor),
    .finish   (finish),
    .quotient (quotient)
  );

  always #5 clk = ~clk;

  // Leaves the caller at the negedge following E0 with open low again.
  task automatic start_pulse(input logic [20:0] a, input logic [20:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    open     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    open = 1'b0;
  endtask

  task automatic wait_result(output logic fin_pre, output logic fin, output logic [20:0] q);
    repeat (20) @(posedge clk);
    @(negedge clk);
    fin_pre = finish;
    @(posedge clk);
    @(negedge clk);
    fin = finish;
    q   = quotient;
  endtask

  task automatic test_reset;
    rst = 1'b1; open = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (finish !== 1'b0 || quotient !== 21'h0) begin
      errors++;
      $display("FAIL reset got finish=%b quotient=%h expected finish=0 quotient=000000", finish, quotient);
    end
    repeat (25) @(posedge clk);
    @(negedge clk);
    checks++;
    if (finish !== 1'b0 || quotient !== 21'h0) begin
      errors++;
      $display("FAIL reset_idle got finish=%b quotient=%h expected finish=0 quotient=000000", finish, quotient);
    end
  endtask

  task automatic test_basic;
    logic fp, f;
    logic [20:0] q;
    start_pulse(21'd100, 21'd7);
    wait_result(fp, f, q);
    checks++;
    if (fp !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency finish after E20 got %b expected 0", fp);
    end
    checks++;
    if (f !== 1'b1 || q !== 21'd14) begin
      errors++;
      $display("FAIL basic got finish=%b quotient=%h expected finish=1 quotient=00000e", f, q);
    end
  endtask

  task automatic test_signs_and_edges;
    logic [20:0] ta [11] = '{21'h1FFF9C, 21'd100,     21'h1FFF9C, 21'h100000, 21'h100000,
                             21'h0FFFFF, 21'd7,       21'h1FFFF9, 21'h1FFFFB, 21'd0,      21'd1000};
    logic [20:0] tb [11] = '{21'd7,      21'h1FFFF9, 21'h1FFFF9, 21'h1FFFFF, 21'd1,
                             21'd1,      21'd100,     21'd100,    21'd0,      21'd0,      21'h1FFFFD};
    logic [20:0] te [11] = '{21'h1FFFF2, 21'h1FFFF2, 21'd14,     21'h0FFFFF, 21'h100000,
                             21'h0FFFFF, 21'd0,       21'd0,      21'h100000, 21'h0FFFFF, 21'h1FFEB3};
    logic fp, f;
    logic [20:0] q;
    for (int i = 0; i < 11; i++) begin
      start_pulse(ta[i], tb[i]);
      wait_result(fp, f, q);
      checks++;
      if (fp !== 1'b0 || f !== 1'b1 || q !== te[i]) begin
        errors++;
        $display("FAIL vector[%0d] %h/%h got pre=%b finish=%b quotient=%h expected pre=0 finish=1 quotient=%h",
                 i, ta[i], tb[i], fp, f, q, te[i]);
      end
    end
  endtask

  task automatic test_level_open;
    @(negedge clk);
    dividend = 21'd1; divisor = 21'd0; open = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (finish !== 1'b0) begin
      errors++;
      $display("FAIL level_latency got finish=%b expected 0", finish);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (finish !== 1'b1 || quotient !== 21'h0FFFFF) begin
      errors++;
      $display("FAIL level_dbz got finish=%b quotient=%h expected finish=1 quotient=0fffff", finish, quotient);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    open = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    checks++;
    if (finish !== 1'b1 || quotient !== 21'h0FFFFF) begin
      errors++;
      $display("FAIL level_hold got finish=%b quotient=%h expected finish=1 quotient=0fffff", finish, quotient);
    end
  endtask

  task automatic test_ignore_in_calc;
    start_pulse(21'd100, 21'd7);
    dividend = 21'd50; divisor = 21'd5;
    repeat (4) @(posedge clk);
    @(negedge clk);
    open = 1'b1;
    @(posedge clk);
    @(negedge clk);
    open = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    checks++;
    if (finish !== 1'b0) begin
      errors++;
      $display("FAIL ignore_latency got finish=%b expected 0", finish);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (finish !== 1'b1 || quotient !== 21'd14) begin
      errors++;
      $display("FAIL ignore got finish=%b quotient=%h expected finish=1 quotient=00000e", finish, quotient);
    end
  endtask

  task automatic test_reset_mid_calc;
    logic fp, f;
    logic [20:0] q;
    start_pulse(21'd200, 21'd10);
    repeat (9) @(posedge clk);
    @(negedge clk);
    checks++;
    if (finish !== 1'b0 || quotient !== 21'd14) begin
      errors++;
      $display("FAIL mid_calc_hold got finish=%b quotient=%h expected finish=0 quotient=00000e", finish, quotient);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (finish !== 1'b0 || quotient !== 21'h0) begin
      errors++;
      $display("FAIL mid_calc_reset got finish=%b quotient=%h expected finish=0 quotient=000000", finish, quotient);
    end
    repeat (25) @(posedge clk);
    @(negedge clk);
    checks++;
    if (finish !== 1'b0 || quotient !== 21'h0) begin
      errors++;
      $display("FAIL mid_calc_idle got finish=%b quotient=%h expected finish=0 quotient=000000", finish, quotient);
    end
    start_pulse(21'd200, 21'd10);
    wait_result(fp, f, q);
    checks++;
    if (f !== 1'b1 || q !== 21'd20) begin
      errors++;
      $display("FAIL after_reset got finish=%b quotient=%h expected finish=1 quotient=000014", f, q);
    end
  endtask

  task automatic test_back_to_back;
    logic fp, f;
    logic [20:0] q;
    start_pulse(21'd1000, 21'h1FFFFD);
    wait_result(fp, f, q);
    checks++;
    if (f !== 1'b1 || q !== 21'h1FFEB3) begin
      errors++;
      $display("FAIL b2b_first got finish=%b quotient=%h expected finish=1 quotient=1ffeb3", f, q);
    end
    start_pulse(21'd9, 21'd3);
    checks++;
    if (finish !== 1'b0 || quotient !== 21'h1FFEB3) begin
      errors++;
      $display("FAIL b2b_restart got finish=%b quotient=%h expected finish=0 quotient=1ffeb3", finish, quotient);
    end
    wait_result(fp, f, q);
    checks++;
    if (fp !== 1'b0 || f !== 1'b1 || q !== 21'd3) begin
      errors++;
      $display("FAIL b2b_second got pre=%b finish=%b quotient=%h expected pre=0 finish=1 quotient=000003", fp, f, q);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs_and_edges();
    test_level_open();
    test_ignore_in_calc();
    test_reset_mid_calc();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
